// File: rtl/guard_pkg.sv
// Shared constants for the obstacle guard: FSM state encoding, duty width/ceiling,
// and a small min() helper used by the duty gate.
package guard_pkg;
  localparam int DUTY_W    = 8;
  localparam int NUM_LANES = 2;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAMP_DOWN = 2'd1,
    HOLD      = 2'd2,
    RAMP_UP   = 2'd3
  } guard_state_e;

  function automatic logic [DUTY_W-1:0] duty_min(input logic [DUTY_W-1:0] a,
                                                 input logic [DUTY_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first tick
// TICK_DIV cycles after reset release.
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk_50M,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_50M) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/obstacle_guard.sv
// Debounces the near-obstacle flag on a slow tick and ramps a shared duty limit
// down to zero / back up, clamping both motor duty commands to that limit.
module obstacle_guard
  import guard_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int CONFIRM    = 3,
  parameter int RELEASE    = 20,
  parameter int RAMP_STEP  = 8,
  parameter int HOLD_TICKS = 50
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              d_val,
  input  logic [DUTY_W-1:0] l_duty_in,
  input  logic [DUTY_W-1:0] r_duty_in,
  output logic [DUTY_W-1:0] l_duty_out,
  output logic [DUTY_W-1:0] r_duty_out,
  output logic              obstacle,
  output logic              stopped,
  output logic [1:0]        state_dbg
);
  localparam logic [3:0]        CONF_C = 4'(CONFIRM);
  localparam logic [7:0]        REL_C  = 8'(RELEASE);
  localparam logic [7:0]        HOLD_C = 8'(HOLD_TICKS);
  localparam logic [DUTY_W:0]   STEP9  = (DUTY_W+1)'(RAMP_STEP);

  logic tick;
  logic [3:0] near_cnt;
  logic [7:0] clear_cnt;
  logic [7:0] hold_cnt;
  logic [DUTY_W-1:0] limit, limit_nxt;
  logic [DUTY_W:0]   dn9, up9;
  guard_state_e state, state_nxt;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_50M (clk_50M),
    .rst     (rst),
    .tick    (tick)
  );

  // obstacle flips on the same edge its qualifying counter reaches threshold
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      near_cnt  <= '0;
      clear_cnt <= '0;
      obstacle  <= 1'b0;
    end else if (tick) begin
      if (d_val) begin
        clear_cnt <= '0;
        if (near_cnt < CONF_C)        near_cnt <= near_cnt + 1'b1;
        if (near_cnt >= CONF_C - 1'b1) obstacle <= 1'b1;
      end else begin
        near_cnt <= '0;
        if (clear_cnt < REL_C)        clear_cnt <= clear_cnt + 1'b1;
        if (clear_cnt >= REL_C - 1'b1) obstacle <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state   <= RUN;
      limit   <= DUTY_MAX;
      stopped <= 1'b0;
    end else begin
      state   <= state_nxt;
      limit   <= limit_nxt;
      stopped <= (state_nxt == HOLD);
    end
  end

  // hold_cnt sits at zero outside HOLD, so it is already cleared on entry
  always_ff @(posedge clk_50M) begin
    if (rst)                              hold_cnt <= '0;
    else if (state != HOLD)               hold_cnt <= '0;
    else if (tick && hold_cnt < HOLD_C)   hold_cnt <= hold_cnt + 1'b1;
  end

  assign dn9 = {1'b0, limit} - STEP9;
  assign up9 = {1'b0, limit} + STEP9;

  always_comb begin
    state_nxt = state;
    limit_nxt = limit;
    unique case (state)
      RUN: begin
        limit_nxt = DUTY_MAX;
        if (obstacle) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (tick) begin
          limit_nxt = dn9[DUTY_W] ? '0 : dn9[DUTY_W-1:0];
          if (dn9[DUTY_W] || dn9[DUTY_W-1:0] == '0) state_nxt = HOLD;
        end
      end
      HOLD: begin
        limit_nxt = '0;
        if (hold_cnt == HOLD_C && !obstacle) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        // the up-step still applies on a tick even when leaving for RAMP_DOWN
        if (tick) limit_nxt = up9[DUTY_W] ? DUTY_MAX : up9[DUTY_W-1:0];
        if (obstacle)                           state_nxt = RAMP_DOWN;
        else if (tick && limit_nxt == DUTY_MAX) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        limit_nxt = DUTY_MAX;
      end
    endcase
  end

  logic [NUM_LANES-1:0][DUTY_W-1:0] duty_in, duty_q;
  assign duty_in = {r_duty_in, l_duty_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_ff @(posedge clk_50M) begin
      if (rst) duty_q[i] <= '0;
      else     duty_q[i] <= duty_min(duty_in[i], limit);
    end
  end

  assign l_duty_out = duty_q[0];
  assign r_duty_out = duty_q[1];
  assign state_dbg  = state;
endmodule

// File: tb/tb_obstacle_guard.sv
// Directed bench for obstacle_guard with small parameters (tick every 4 clocks).
// Samples land 1 ns after the edge one clock past each tick edge.
module tb_obstacle_guard;
  logic       clk_50M = 1'b0;
  logic       rst;
  logic       d_val;
  logic [7:0] l_duty_in, r_duty_in;
  logic [7:0] l_duty_out, r_duty_out;
  logic       obstacle, stopped;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  obstacle_guard #(
    .TICK_DIV(4), .CONFIRM(3), .RELEASE(4), .RAMP_STEP(64), .HOLD_TICKS(2)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .d_val      (d_val),
    .l_duty_in  (l_duty_in),
    .r_duty_in  (r_duty_in),
    .l_duty_out (l_duty_out),
    .r_duty_out (r_duty_out),
    .obstacle   (obstacle),
    .stopped    (stopped),
    .state_dbg  (state_dbg)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic chk_out(input string tag, input int l, input int r, input int st);
    check({tag, "_l"}, int'(l_duty_out), l);
    check({tag, "_r"}, int'(r_duty_out), r);
    check({tag, "_st"}, int'(state_dbg), st);
  endtask

  initial begin
    rst = 1'b1; d_val = 1'b0; l_duty_in = 8'd200; r_duty_in = 8'd150;
    cyc(3);
    chk_out("rst", 0, 0, 0);
    check("rst_obs", int'(obstacle), 0);
    check("rst_stop", int'(stopped), 0);

    // P1: outputs follow inputs one clock later
    rst = 1'b0;
    cyc(1);
    chk_out("idle", 200, 150, 0);

    // two-tick glitch on d_val never confirms
    d_val = 1'b1;
    cyc(4); check("gl_t1_obs", int'(obstacle), 0);
    cyc(4); check("gl_t2_obs", int'(obstacle), 0);
    d_val = 1'b0;
    cyc(4); check("gl_t3_obs", int'(obstacle), 0);
    chk_out("gl", 200, 150, 0);

    // held obstacle: confirm on 3rd tick, ramp down to HOLD
    d_val = 1'b1;
    cyc(4); check("cf_t1_obs", int'(obstacle), 0);
    cyc(4); check("cf_t2_obs", int'(obstacle), 0);
    cyc(4); check("cf_t3_obs", int'(obstacle), 1);
    check("cf_t3_st", int'(state_dbg), 1);
    cyc(4); chk_out("dn191", 191, 150, 1);
    cyc(4); chk_out("dn127", 127, 127, 1);
    cyc(4); chk_out("dn63", 63, 63, 1);
    cyc(4); chk_out("dn0", 0, 0, 2);
    check("dn0_stop", int'(stopped), 1);

    // release: 4 clear ticks, then ramp back to RUN
    d_val = 1'b0;
    cyc(4); check("rl1_obs", int'(obstacle), 1); check("rl1_st", int'(state_dbg), 2);
    cyc(8); check("rl3_obs", int'(obstacle), 1); check("rl3_st", int'(state_dbg), 2);
    cyc(4); check("rl4_obs", int'(obstacle), 0);
    chk_out("up_start", 0, 0, 3);
    check("up_stop", int'(stopped), 0);
    cyc(4); chk_out("up64", 64, 64, 3);
    cyc(4); chk_out("up128", 128, 128, 3);
    cyc(4); chk_out("up192", 192, 150, 3);
    cyc(4); chk_out("up255", 200, 150, 0);

    // second obstacle: clears quickly, HOLD minimum governs exit,
    // then re-confirm mid ramp-up continues down from current limit
    d_val = 1'b1;
    cyc(12); check("c2_obs", int'(obstacle), 1); check("c2_st", int'(state_dbg), 1);
    d_val = 1'b0;
    cyc(4); chk_out("c2_191", 191, 150, 1);
    cyc(4); chk_out("c2_127", 127, 127, 1);
    cyc(4); chk_out("c2_63", 63, 63, 1);
    cyc(4); chk_out("c2_hold", 0, 0, 2);
    check("c2_hold_obs", int'(obstacle), 0);
    cyc(4); check("c2_hmin_st", int'(state_dbg), 2);
    d_val = 1'b1;
    cyc(4); chk_out("c2_up0", 0, 0, 3);
    cyc(4); chk_out("c2_up64", 64, 64, 3);
    cyc(4); chk_out("re_128", 128, 128, 1);
    check("re_obs", int'(obstacle), 1);
    cyc(4); chk_out("re_64", 64, 64, 1);
    cyc(4); chk_out("re_0", 0, 0, 2);
    check("re_stop", int'(stopped), 1);

    // reset in HOLD returns everything to reset values
    rst = 1'b1; d_val = 1'b0;
    cyc(1);
    chk_out("mrst", 0, 0, 0);
    check("mrst_obs", int'(obstacle), 0);
    check("mrst_stop", int'(stopped), 0);
    check("mrst_lim", int'(dut.limit), 255);
    rst = 1'b0;
    cyc(1); chk_out("post", 200, 150, 0);
    l_duty_in = 8'd17; r_duty_in = 8'd255;
    cyc(8); chk_out("post2", 17, 255, 0);
    check("post2_obs", int'(obstacle), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
